// File: rtl/input_conditioner.sv
// Synchronises and debounces 18 switch and 4 button pins, and produces button-press events.
// Define INPUT_COND_PRESS_LATCH_EN to make o_btn_press a sticky flag cleared by i_press_clr.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [17:0] io_sw_i,
    input  logic [3:0]  io_btn_i,
    input  logic [3:0]  i_press_clr,
    output logic [17:0] o_sw_clean,
    output logic [3:0]  o_btn_clean,
    output logic [3:0]  o_btn_press
);

    localparam int NSW   = 18;
    localparam int NBTN  = 4;
    localparam int NBITS = NSW + NBTN;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBITS-1:0] s1_q, s2_q;
    logic [NBITS-1:0] clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q [NBITS];
    logic [CNT_W-1:0] cnt_d [NBITS];
    logic [NBTN-1:0]  press_q, press_d;
    logic [NBTN-1:0]  btn_rise;

    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < NBITS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == TERM) begin
                clean_d[i] = s2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // A press is only the 0->1 transition of a button's clean level.
    assign btn_rise = clean_d[NBITS-1:NSW] & ~clean_q[NBITS-1:NSW];

`ifdef INPUT_COND_PRESS_LATCH_EN
    always_comb begin
        press_d = btn_rise | (press_q & ~i_press_clr);
    end
`else
    logic unused_press_clr;
    assign unused_press_clr = ^i_press_clr;

    always_comb begin
        press_d = btn_rise;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            clean_q <= '0;
            press_q <= '0;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= {io_btn_i, io_sw_i};
            s2_q    <= s1_q;
            clean_q <= clean_d;
            press_q <= press_d;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign o_sw_clean  = clean_q[NSW-1:0];
    assign o_btn_clean = clean_q[NBITS-1:NSW];
    assign o_btn_press = press_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed table-driven bench for input_conditioner with DEBOUNCE_CYCLES=4; works in both press builds.
module tb_input_conditioner;

    logic        clk;
    logic        rst;
    logic [17:0] sw;
    logic [3:0]  btn;
    logic [3:0]  clr;
    logic [17:0] sw_clean;
    logic [3:0]  btn_clean;
    logic [3:0]  btn_press;

`ifdef INPUT_COND_PRESS_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .io_sw_i     (sw),
        .io_btn_i    (btn),
        .i_press_clr (clr),
        .o_sw_clean  (sw_clean),
        .o_btn_clean (btn_clean),
        .o_btn_press (btn_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [17:0] sw;
        logic [3:0]  btn;
        logic [3:0]  clr;
        int          n;
        logic [17:0] esw;
        logic [3:0]  ebtn;
        logic [3:0]  epl;
        logic [3:0]  epp;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic r, input logic [17:0] s, input logic [3:0] b,
                                input logic [3:0] c, input int n, input logic [17:0] esw,
                                input logic [3:0] ebtn, input logic [3:0] epl,
                                input logic [3:0] epp);
        vec_t v;
        v.rst = r; v.sw = s; v.btn = b; v.clr = c; v.n = n;
        v.esw = esw; v.ebtn = ebtn; v.epl = epl; v.epp = epp;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; sw = '0; btn = '0; clr = '0;
        //   rst sw        btn      clr      n  esw       ebtn     press(latch) press(pulse)
        add(1, 18'h3FFFF, 4'h0,   4'h0,    3, 18'h0,     4'h0,    4'h0,   4'h0);   // 0 reset with pins high
        add(0, 18'h3FFFF, 4'h0,   4'h0,    5, 18'h0,     4'h0,    4'h0,   4'h0);   // 1 edges k..k+4
        add(0, 18'h3FFFF, 4'h0,   4'h0,    1, 18'h3FFFF, 4'h0,    4'h0,   4'h0);   // 2 edge k+5
        add(0, 18'h3FFFF, 4'h1,   4'h0,    3, 18'h3FFFF, 4'h0,    4'h0,   4'h0);   // 3 3-cycle glitch
        add(0, 18'h3FFFF, 4'h0,   4'h0,    8, 18'h3FFFF, 4'h0,    4'h0,   4'h0);   // 4 glitch rejected
        add(0, 18'h3FFFF, 4'h4,   4'h0,    5, 18'h3FFFF, 4'h0,    4'h0,   4'h0);   // 5 btn2 pending
        add(0, 18'h3FFFF, 4'h4,   4'h0,    1, 18'h3FFFF, 4'h4,    4'h4,   4'h4);   // 6 btn2 press
        add(0, 18'h3FFFF, 4'h4,   4'h0,    1, 18'h3FFFF, 4'h4,    4'h4,   4'h0);   // 7 sticky vs pulse
        add(0, 18'h3FFFF, 4'h0,   4'h0,    6, 18'h3FFFF, 4'h0,    4'h4,   4'h0);   // 8 release, no event
        add(0, 18'h3FFFF, 4'h0,   4'h4,    1, 18'h3FFFF, 4'h0,    4'h0,   4'h0);   // 9 clear
        add(0, 18'h3FFFF, 4'h0,   4'h0,    1, 18'h3FFFF, 4'h0,    4'h0,   4'h0);   // 10
        add(0, 18'h3FFFF, 4'h2,   4'h0,    5, 18'h3FFFF, 4'h0,    4'h0,   4'h0);   // 11 btn1 pending
        add(0, 18'h3FFFF, 4'h2,   4'h2,    1, 18'h3FFFF, 4'h2,    4'h2,   4'h2);   // 12 set/clear collision
        add(0, 18'h3FFFF, 4'h2,   4'h0,    1, 18'h3FFFF, 4'h2,    4'h2,   4'h0);   // 13
        add(0, 18'h3FFFF, 4'h2,   4'h2,    1, 18'h3FFFF, 4'h2,    4'h0,   4'h0);   // 14 clear
        add(0, 18'h3FFFF, 4'h0,   4'h0,    6, 18'h3FFFF, 4'h0,    4'h0,   4'h0);   // 15 release
        add(0, 18'h0,     4'h0,   4'h0,    6, 18'h0,     4'h0,    4'h0,   4'h0);   // 16 switches fall together
        add(0, 18'h20,    4'h0,   4'h0,    3, 18'h0,     4'h0,    4'h0,   4'h0);   // 17 sw5 counting
        add(1, 18'h20,    4'h0,   4'h0,    1, 18'h0,     4'h0,    4'h0,   4'h0);   // 18 reset mid-count
        add(0, 18'h20,    4'h0,   4'h0,    5, 18'h0,     4'h0,    4'h0,   4'h0);   // 19 count restarts
        add(0, 18'h20,    4'h0,   4'h0,    1, 18'h20,    4'h0,    4'h0,   4'h0);   // 20
        add(0, 18'h20,    4'h8,   4'h0,    5, 18'h20,    4'h0,    4'h0,   4'h0);   // 21 btn3 pending
        add(0, 18'h20,    4'h8,   4'h0,    1, 18'h20,    4'h8,    4'h8,   4'h8);   // 22 btn3 press
        add(0, 18'h20,    4'h8,   4'h0,    1, 18'h20,    4'h8,    4'h8,   4'h0);   // 23 single pulse
        add(0, 18'h20,    4'h0,   4'h0,    6, 18'h20,    4'h0,    4'h8,   4'h0);   // 24 release
        add(0, 18'h20,    4'h0,   4'h8,    1, 18'h20,    4'h0,    4'h0,   4'h0);   // 25 clear

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; sw = tbl[i].sw; btn = tbl[i].btn; clr = tbl[i].clr;
            repeat (tbl[i].n) @(posedge clk);
            @(negedge clk);
            check($sformatf("row%0d sw_clean", i), 32'(sw_clean), 32'(tbl[i].esw));
            check($sformatf("row%0d btn_clean", i), 32'(btn_clean), 32'(tbl[i].ebtn));
            check($sformatf("row%0d btn_press", i), 32'(btn_press),
                  32'(LATCH ? tbl[i].epl : tbl[i].epp));
        end

        // Asynchronous reset between edges clears the outputs immediately.
        clr = '0; btn = 4'h8; sw = 18'h3FFFF;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("async pre sw", 32'(sw_clean), 32'h3FFFF);
        check("async pre btn", 32'(btn_clean), 32'h8);
        #2 rst = 1'b1;
        #1;
        check("async sw", 32'(sw_clean), 32'h0);
        check("async btn", 32'(btn_clean), 32'h0);
        check("async press", 32'(btn_press), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("post async sw k+4", 32'(sw_clean), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("post async sw k+5", 32'(sw_clean), 32'h3FFFF);
        check("post async press", 32'(btn_press), 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
